// File: rtl/blink_sequencer_if.sv
// blink_sequencer configuration/control bundle.
// master = config source, slave = sequencer.
interface blink_sequencer_if #(
  parameter int AW        = 3,
  parameter int DUR_WIDTH = 16
);
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic                 cfg_level;
  logic [DUR_WIDTH-1:0] cfg_duration;
  logic [AW-1:0]        last_step;
  logic                 loop;
  logic                 start;
  logic                 stop;
  logic                 led;
  logic                 busy;
  logic [AW-1:0]        step;
  logic                 done;

  modport master (
    output cfg_we,
    output cfg_addr,
    output cfg_level,
    output cfg_duration,
    output last_step,
    output loop,
    output start,
    output stop,
    input  led,
    input  busy,
    input  step,
    input  done
  );

  modport slave (
    input  cfg_we,
    input  cfg_addr,
    input  cfg_level,
    input  cfg_duration,
    input  last_step,
    input  loop,
    input  start,
    input  stop,
    output led,
    output busy,
    output step,
    output done
  );
endinterface

// File: rtl/blink_sequencer.sv
// Table-driven blink pattern sequencer.
// Walks {level, duration} steps on a prescaled tick.
module blink_sequencer #(
  parameter int PRESCALE  = 10000,
  parameter int DUR_WIDTH = 16,
  parameter int STEPS     = 8
) (
  input  logic               clock,
  input  logic               reset,
  blink_sequencer_if.slave   bus
);
  localparam int AW = $clog2(STEPS);
  localparam int PW = (PRESCALE > 1) ?
                      $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(PRESCALE - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e               state_q, state_d;
  logic [STEPS-1:0]     lvl_q, lvl_d;
  logic [DUR_WIDTH-1:0] dur_q [STEPS];
  logic [DUR_WIDTH-1:0] dur_d [STEPS];
  logic                 wlvl_q, wlvl_d;
  logic [DUR_WIDTH-1:0] wdur_q, wdur_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic [DUR_WIDTH-1:0] cnt_q, cnt_d;
  logic [AW-1:0]        step_q, step_d;
  logic [AW-1:0]        last_q, last_d;
  logic                 loop_q, loop_d;
  logic                 led_q, led_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 tick;
  logic                 step_end;
  logic                 enter;
  logic [AW-1:0]        nxt;

  // Pattern table writes, accepted in any state.
  always_comb begin
    lvl_d = lvl_q;
    dur_d = dur_q;
    if (bus.cfg_we) begin
      lvl_d[bus.cfg_addr] = bus.cfg_level;
      dur_d[bus.cfg_addr] = bus.cfg_duration;
    end
  end

  assign tick = (state_q == RUN) &&
                (pre_q == PRE_MAX);
  assign step_end = tick && (cnt_q == wdur_q);

  // Next-state, step walk and output decode.
  always_comb begin
    state_d = state_q;
    wlvl_d  = wlvl_q;
    wdur_d  = wdur_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    last_d  = last_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    enter   = 1'b0;
    nxt     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          last_d  = bus.last_step;
          loop_d  = bus.loop;
          enter   = 1'b1;
          nxt     = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (step_end) begin
            if (step_q != last_q) begin
              enter = 1'b1;
              nxt   = step_q + 1'b1;
            end else if (loop_q) begin
              enter = 1'b1;
              nxt   = '0;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
    endcase

    // Working copy is taken at step entry, so
    // a table write to the live step waits for
    // the next visit.
    if (enter) begin
      step_d = nxt;
      wlvl_d = lvl_q[nxt];
      wdur_d = dur_q[nxt];
      cnt_d  = '0;
    end

    if (state_d == IDLE) begin
      step_d = '0;
      pre_d  = '0;
      cnt_d  = '0;
    end else if (state_q == IDLE) begin
      pre_d = '0;
    end

    busy_d = (state_d == RUN);
    led_d  = (state_d == RUN) && wlvl_d;
  end

  // All state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      dur_q   <= '{default: '0};
      wlvl_q  <= 1'b0;
      wdur_q  <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      dur_q   <= dur_d;
      wlvl_q  <= wlvl_d;
      wdur_q  <= wdur_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.step = step_q;
  assign bus.done = done_q;

endmodule
